// File: rtl/flush_sequencer.sv
// End-of-image flush controller: drain, flush each packing stage in order, pulse a pipeline reset, report done.
// Optional FLUSH_SEQ_ABORT_EN adds an `abort` input that cuts the sequence short to the pipeline reset.
module flush_sequencer #(
  parameter int NUM_STAGES   = 2,
  parameter int DRAIN_CYCLES = 4,
  parameter int WAIT_CYCLES  = 4,
  parameter int TIMEOUT      = 255,
  localparam int SW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1,
  localparam int CW = $clog2((DRAIN_CYCLES > TIMEOUT) ? DRAIN_CYCLES : TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_image,
`ifdef FLUSH_SEQ_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [NUM_STAGES-1:0] stage_idle,
  output logic [NUM_STAGES-1:0] flush,
  output logic                  rst_pipeline,
  output logic                  done_flush,
  output logic                  busy,
  output logic [SW-1:0]         cur_stage,
  output logic                  timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_DRAIN, S_FLUSH, S_SETTLE, S_RESET, S_DONE
  } state_t;

  state_t        state_reg;
  logic [SW-1:0] idx_reg;
  logic [CW-1:0] cnt_reg;
  logic          pending_reg;
  logic          timeout_err_reg;

  logic settled;
  logic timed_out;
  logic abort_req;

  assign settled   = (cnt_reg >= CW'(WAIT_CYCLES - 1)) && stage_idle[idx_reg];
  assign timed_out = (cnt_reg == CW'(TIMEOUT - 1));

`ifdef FLUSH_SEQ_ABORT_EN
  assign abort_req = abort &&
                     (state_reg == S_DRAIN || state_reg == S_FLUSH || state_reg == S_SETTLE);
`else
  assign abort_req = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      idx_reg         <= '0;
      cnt_reg         <= '0;
      pending_reg     <= 1'b0;
      timeout_err_reg <= 1'b0;
    end else begin
      // A single request is remembered while busy; more collapse into it.
      if (state_reg != S_IDLE && done_image) pending_reg <= 1'b1;

      case (state_reg)
        S_IDLE: begin
          if (done_image || pending_reg) begin
            state_reg   <= S_DRAIN;
            cnt_reg     <= '0;
            pending_reg <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (cnt_reg == CW'(DRAIN_CYCLES - 1)) begin
            state_reg <= S_FLUSH;
            idx_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CW'(1);
          end
        end
        S_FLUSH: begin
          state_reg <= S_SETTLE;
          cnt_reg   <= '0;
        end
        S_SETTLE: begin
          if (!timed_out) cnt_reg <= cnt_reg + CW'(1);
          if (settled || timed_out) begin
            if (!settled) timeout_err_reg <= 1'b1;
            if (idx_reg == SW'(NUM_STAGES - 1)) begin
              state_reg <= S_RESET;
            end else begin
              state_reg <= S_FLUSH;
              idx_reg   <= idx_reg + SW'(1);
            end
          end
        end
        S_RESET: state_reg <= S_DONE;
        S_DONE:  state_reg <= S_IDLE;
        default: state_reg <= S_IDLE;
      endcase

      // Abort overrides whatever the sequence would have done next.
      if (abort_req) begin
        state_reg   <= S_RESET;
        pending_reg <= 1'b0;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_flush
      assign flush[gi] = (state_reg == S_FLUSH) && (idx_reg == SW'(gi));
    end
  endgenerate

  assign rst_pipeline = (state_reg == S_RESET);
  assign done_flush   = (state_reg == S_DONE);
  assign busy         = (state_reg != S_IDLE);
  assign cur_stage    = (state_reg == S_FLUSH || state_reg == S_SETTLE) ? idx_reg : '0;
  assign timeout_err  = timeout_err_reg;

endmodule
